// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the DAC sample controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_ctrl_pkg;

    localparam int              DAC_W        = 10;
    localparam logic [DAC_W-1:0] DAC_MIDSCALE = 10'd512;
    localparam logic [7:0]      UNDERRUN_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        SETTLE
    } dac_ctrl_state_t;

endpackage

// File: rtl/dac_rate_timer.sv
// Down-counter pacing the WAIT and SETTLE phases; loads a value and counts to zero.
// Latency: done is high while the count is zero; a load of N gives N+1 cycles until the next-state decision.
// Backpressure: none; the FSM decides when to reload.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load         capture load_val (takes priority over counting)
//   load_val     phase length minus 1
//   done         count has reached zero
module dac_rate_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             done
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/dac_sample_ctrl.sv
// Paces and round-robin arbitrates two 10-bit code sources into the DAC code register.
// Latency: a transfer in SAMPLE at cycle N updates dac_code/grant_id and pulses dac_load at N+1.
// Backpressure: readys are offered only in the single SAMPLE cycle, to at most one source.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable                    run/stop; low returns the FSM to IDLE
//   rate_div                  WAIT length minus 1, captured on WAIT entry
//   srcN_valid/code/ready     source N offer; ready = accepted this cycle
//   dac_code, dac_load        registered DAC code and its one-cycle update strobe
//   grant_id                  source that produced the current dac_code
//   underrun_cnt              saturating count of SAMPLE slots with no offer
//   busy                      FSM not in IDLE
// Build option: DAC_CTRL_MIDSCALE_PARK_EN parks dac_code at midscale on each underrun.
module dac_sample_ctrl
    import dac_ctrl_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             src0_valid,
    input  logic [DAC_W-1:0] src0_code,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [DAC_W-1:0] src1_code,
    output logic             src1_ready,
    output logic [DAC_W-1:0] dac_code,
    output logic             dac_load,
    output logic             grant_id,
    output logic [7:0]       underrun_cnt,
    output logic             busy
);

    // SETTLE reload value; unused when SETTLE_CYC is 0 since SETTLE is skipped.
    localparam logic [DIV_W-1:0] SETTLE_LOAD = DIV_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    dac_ctrl_state_t  state_q, state_d;
    logic [DAC_W-1:0] dac_code_q, dac_code_d;
    logic             dac_load_q, dac_load_d;
    logic             grant_id_q, grant_id_d;
    logic [7:0]       underrun_q, underrun_d;
    logic             rr_ptr_q, rr_ptr_d;

    logic             sample_slot;
    logic             winner;
    logic             t_load;
    logic [DIV_W-1:0] t_val;
    logic             t_done;

    dac_rate_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_comb begin
        state_d     = state_q;
        dac_code_d  = dac_code_q;
        dac_load_d  = 1'b0;
        grant_id_d  = grant_id_q;
        underrun_d  = underrun_q;
        rr_ptr_d    = rr_ptr_q;
        src0_ready  = 1'b0;
        src1_ready  = 1'b0;

        sample_slot = (state_q == SAMPLE) && enable;
        // Lone requester wins outright; on contention the round-robin pointer decides.
        winner      = (src0_valid && src1_valid) ? rr_ptr_q : src1_valid;

        if (sample_slot) begin
            if (src0_valid || src1_valid) begin
                src0_ready = ~winner;
                src1_ready = winner;
                dac_code_d = winner ? src1_code : src0_code;
                dac_load_d = 1'b1;
                grant_id_d = winner;
                rr_ptr_d   = ~winner;
            end else begin
                underrun_d = (underrun_q == UNDERRUN_MAX) ? underrun_q : underrun_q + 8'd1;
`ifdef DAC_CTRL_MIDSCALE_PARK_EN
                dac_code_d = DAC_MIDSCALE;
                dac_load_d = 1'b1;
`endif
            end
        end

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WAIT;
                WAIT:    if (t_done) state_d = SAMPLE;
                SAMPLE:  state_d = (SETTLE_CYC > 0) ? SETTLE : WAIT;
                SETTLE:  if (t_done) state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end

        // Reload the timer on every entry into a timed phase; rate_div is captured here.
        t_load = (state_d != state_q) && ((state_d == WAIT) || (state_d == SETTLE));
        t_val  = (state_d == WAIT) ? rate_div : SETTLE_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dac_code_q <= DAC_MIDSCALE;
            dac_load_q <= 1'b0;
            grant_id_q <= 1'b0;
            underrun_q <= 8'd0;
            rr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dac_code_q <= dac_code_d;
            dac_load_q <= dac_load_d;
            grant_id_q <= grant_id_d;
            underrun_q <= underrun_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign dac_code     = dac_code_q;
    assign dac_load     = dac_load_q;
    assign grant_id     = grant_id_q;
    assign underrun_cnt = underrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dac_sample_ctrl.sv
// Directed bench for dac_sample_ctrl (DIV_W=16, SETTLE_CYC=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived from the sample period rate_div+2+SETTLE_CYC.
module tb_dac_sample_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] rate_div;
    logic        src0_valid, src1_valid;
    logic [9:0]  src0_code, src1_code;
    logic        src0_ready, src1_ready;
    logic [9:0]  dac_code;
    logic        dac_load;
    logic        grant_id;
    logic [7:0]  underrun_cnt;
    logic        busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    dac_sample_ctrl #(.DIV_W(16), .SETTLE_CYC(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rate_div     (rate_div),
        .src0_valid   (src0_valid),
        .src0_code    (src0_code),
        .src0_ready   (src0_ready),
        .src1_valid   (src1_valid),
        .src1_code    (src1_code),
        .src1_ready   (src1_ready),
        .dac_code     (dac_code),
        .dac_load     (dac_load),
        .grant_id     (grant_id),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0;
        src0_valid = 1'b0; src1_valid = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; rate_div = 16'd3;
        src0_valid = 1'b0; src1_valid = 1'b0; src0_code = '0; src1_code = '0;
        step(); step();
        rst = 1'b0;
        step(); step(); step();
        chk_cnt++; if (dac_code !== 10'd512) $display("FAIL reset_code: got %0d want 512", dac_code); else pass_cnt++;
        chk_cnt++; if (dac_load !== 1'b0) $display("FAIL reset_load: got %0b want 0", dac_load); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if (underrun_cnt !== 8'd0) $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); else pass_cnt++;
        chk_cnt++; if ({src1_ready, src0_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {src1_ready, src0_ready}); else pass_cnt++;
        chk_cnt++; if (grant_id !== 1'b0) $display("FAIL reset_grant: got %0b want 0", grant_id); else pass_cnt++;
    endtask

    task automatic test_single();
        int  bad_rdy = 0;
        int  bad_load = 0;
        int  nrdy = 0;
        logic prev = 1'b0;
        logic exp;
        do_reset();
        rate_div = 16'd3; src0_valid = 1'b1; src0_code = 10'd100; enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            exp = (i >= 5) && (((i - 5) % 7) == 0);
            if (src0_ready !== exp || src1_ready !== 1'b0) bad_rdy++;
            if (prev) begin
                if (dac_load !== 1'b1 || dac_code !== 10'd100 || grant_id !== 1'b0) bad_load++;
            end else if (dac_load !== 1'b0) begin
                bad_load++;
            end
            if (src0_ready === 1'b1) nrdy++;
            prev = (src0_ready === 1'b1);
        end
        chk_cnt++; if (bad_rdy != 0) $display("FAIL single_ready_pattern: got %0d bad cycles want 0", bad_rdy); else pass_cnt++;
        chk_cnt++; if (bad_load != 0) $display("FAIL single_load_pattern: got %0d bad cycles want 0", bad_load); else pass_cnt++;
        chk_cnt++; if (nrdy != 4) $display("FAIL single_ready_count: got %0d want 4", nrdy); else pass_cnt++;
        chk_cnt++; if (dac_code !== 10'd100) $display("FAIL single_code: got %0d want 100", dac_code); else pass_cnt++;
        enable = 1'b0; src0_valid = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int       nl = 0;
        int       both = 0;
        logic [3:0] gseq = '0;
        logic [9:0] codes [4];
        logic [9:0] exp_code;
        do_reset();
        rate_div = 16'd3; enable = 1'b1;
        src0_valid = 1'b1; src0_code = 10'h155;
        src1_valid = 1'b1; src1_code = 10'h2AA;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (src0_ready === 1'b1 && src1_ready === 1'b1) both++;
            if (dac_load === 1'b1) begin
                if (nl < 4) begin
                    gseq = {gseq[2:0], grant_id};
                    codes[nl] = dac_code;
                end
                nl++;
            end
        end
        chk_cnt++; if (nl != 4) $display("FAIL rr_load_count: got %0d want 4", nl); else pass_cnt++;
        chk_cnt++; if (both != 0) $display("FAIL rr_double_ready: got %0d cycles want 0", both); else pass_cnt++;
        chk_cnt++; if (gseq !== 4'b0101) $display("FAIL rr_grant_seq: got %b want 0101", gseq); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            exp_code = (k % 2 == 0) ? 10'h155 : 10'h2AA;
            chk_cnt++;
            if (nl < 4 || codes[k] !== exp_code) $display("FAIL rr_code_%0d: got %h want %h", k, codes[k], exp_code);
            else pass_cnt++;
        end
        enable = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0;
        step();
    endtask

    task automatic test_underrun();
        int       nl = 0;
        logic [9:0] exp_code;
        int       exp_nl;
        do_reset();
        rate_div = 16'd3; enable = 1'b1;
        src0_valid = 1'b1; src0_code = 10'd77;
        for (int i = 1; i <= 27; i++) begin
            step();
            if (i == 6) src0_valid = 1'b0;
            if (i >= 7 && dac_load === 1'b1) nl++;
        end
`ifdef DAC_CTRL_MIDSCALE_PARK_EN
        exp_code = 10'd512; exp_nl = 3;
`else
        exp_code = 10'd77;  exp_nl = 0;
`endif
        chk_cnt++; if (underrun_cnt !== 8'd3) $display("FAIL underrun_count: got %0d want 3", underrun_cnt); else pass_cnt++;
        chk_cnt++; if (nl != exp_nl) $display("FAIL underrun_loads: got %0d want %0d", nl, exp_nl); else pass_cnt++;
        chk_cnt++; if (dac_code !== exp_code) $display("FAIL underrun_code: got %0d want %0d", dac_code, exp_code); else pass_cnt++;
        chk_cnt++; if (grant_id !== 1'b0) $display("FAIL underrun_grant: got %0b want 0", grant_id); else pass_cnt++;
        enable = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        rate_div = 16'd0; enable = 1'b1;
        // Period 4: slots at cycle 2+4k, counter visible one cycle later.
        for (int i = 1; i <= 1300; i++) begin
            step();
            if (i == 400) begin
                chk_cnt++; if (underrun_cnt !== 8'd100) $display("FAIL sat_mid: got %0d want 100", underrun_cnt); else pass_cnt++;
            end
            if (i == 1015) begin
                chk_cnt++; if (underrun_cnt !== 8'd254) $display("FAIL sat_edge: got %0d want 254", underrun_cnt); else pass_cnt++;
            end
        end
        chk_cnt++; if (underrun_cnt !== 8'd255) $display("FAIL sat_hold: got %0d want 255", underrun_cnt); else pass_cnt++;
        enable = 1'b0;
        step();
    endtask

    task automatic test_enable_drop();
        int first = -1;
        do_reset();
        rate_div = 16'd3; enable = 1'b1;
        src0_valid = 1'b1; src0_code = 10'd200;
        for (int i = 1; i <= 6; i++) step();
        // Cycle 6 is the first SETTLE cycle carrying the load from SAMPLE.
        chk_cnt++; if (dac_load !== 1'b1 || dac_code !== 10'd200) $display("FAIL drop_prior_load: got load=%0b code=%0d want 1/200", dac_load, dac_code); else pass_cnt++;
        enable = 1'b0;
        step();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL drop_busy: got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if ({src1_ready, src0_ready} !== 2'b00) $display("FAIL drop_ready: got %b want 00", {src1_ready, src0_ready}); else pass_cnt++;
        step(); step();
        enable = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j == 1) begin
                chk_cnt++; if (busy !== 1'b1) $display("FAIL reen_busy: got %0b want 1", busy); else pass_cnt++;
            end
            if (first < 0 && src0_ready === 1'b1) first = j;
        end
        chk_cnt++; if (first != 5) $display("FAIL reen_first_ready: got %0d want 5", first); else pass_cnt++;
        enable = 1'b0; src0_valid = 1'b0;
        step();
    endtask

    task automatic test_sample_disable();
        do_reset();
        rate_div = 16'd3; enable = 1'b1;
        src0_valid = 1'b1; src0_code = 10'd300;
        for (int i = 1; i <= 5; i++) step();
        chk_cnt++; if (src0_ready !== 1'b1) $display("FAIL sd_ready_on: got %0b want 1", src0_ready); else pass_cnt++;
        enable = 1'b0;
        #1;
        chk_cnt++; if (src0_ready !== 1'b0) $display("FAIL sd_ready_off: got %0b want 0", src0_ready); else pass_cnt++;
        step();
        chk_cnt++; if (dac_load !== 1'b0 || dac_code !== 10'd512) $display("FAIL sd_no_load: got load=%0b code=%0d want 0/512", dac_load, dac_code); else pass_cnt++;
        chk_cnt++; if (underrun_cnt !== 8'd0) $display("FAIL sd_no_underrun: got %0d want 0", underrun_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rate_div = 16'd3; enable = 1'b1;
        src0_valid = 1'b1; src0_code = 10'd300;
        for (int i = 1; i <= 5; i++) step();
        rst = 1'b1;
        step();
        chk_cnt++; if (dac_load !== 1'b0 || dac_code !== 10'd512) $display("FAIL rstmid_discard: got load=%0b code=%0d want 0/512", dac_load, dac_code); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", busy); else pass_cnt++;
        rst = 1'b0; enable = 1'b0; src0_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_underrun();
        test_saturation();
        test_enable_drop();
        test_sample_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
